// File: rtl/uart_pkg.sv
// Shared UART constants: baud codes, default bit divisors and the
// transmit scheduler state encoding.
package uart_pkg;

  localparam logic [1:0] BAUD_9600  = 2'b00;
  localparam logic [1:0] BAUD_19200 = 2'b01;
  localparam logic [1:0] BAUD_38400 = 2'b10;
  localparam logic [1:0] BAUD_57600 = 2'b11;

  localparam int DIV_W            = 13;
  localparam int DIV_9600_DEF     = 5208;
  localparam int DIV_19200_DEF    = 2604;
  localparam int DIV_38400_DEF    = 1302;
  localparam int DIV_57600_DEF    = 868;
  localparam logic [DIV_W-1:0] DIV_ZERO = 13'd0;
  localparam logic [DIV_W-1:0] DIV_ONE  = 13'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  function automatic logic [DIV_W-1:0] baud_div(
    input logic [1:0]       code,
    input logic [DIV_W-1:0] d9600,
    input logic [DIV_W-1:0] d19200,
    input logic [DIV_W-1:0] d38400,
    input logic [DIV_W-1:0] d57600
  );
    logic [DIV_W-1:0] d;
    case (code)
      BAUD_9600:  d = d9600;
      BAUD_19200: d = d19200;
      BAUD_38400: d = d38400;
      BAUD_57600: d = d57600;
      default:    d = d9600;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Per-frame bit-period divider: counts 0..divisor-1 and ticks on the last count.
// tick_next announces the tick one clock early so callers can register decodes.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick,
  output logic             tick_next
);

  logic [DIV_W-1:0] count_r;
  logic [DIV_W-1:0] count_next_s;
  logic             tick_r;

  // Next count: cleared on request, wraps after the last count of a bit.
  always_comb begin
    count_next_s = count_r;
    if (clear) begin
      count_next_s = DIV_ZERO;
    end else if (count_r >= divisor - DIV_ONE) begin
      count_next_s = DIV_ZERO;
    end else begin
      count_next_s = count_r + DIV_ONE;
    end
  end

  assign tick_next = (count_next_s == divisor - DIV_ONE);

  // Count and tick registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= DIV_ZERO;
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      tick_r  <= tick_next;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one 8N1 TX line between N_REQ requesters,
// each frame using the winner's latched byte and baud divisor.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DIV_9600  = DIV_9600_DEF,
  parameter int DIV_19200 = DIV_19200_DEF,
  parameter int DIV_38400 = DIV_38400_DEF,
  parameter int DIV_57600 = DIV_57600_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [2*N_REQ-1:0]         req_baud,
  output logic [N_REQ-1:0]           req_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       tx
);

  localparam int GW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] REQ_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  tx_state_e        state_r, state_next_s;
  logic [2:0]       bit_r, bit_next_s;
  logic [7:0]       data_r;
  logic [1:0]       baud_r;
  logic [GW-1:0]    last_r, grant_r, winner_s;
  logic             any_valid_s;
  logic [N_REQ-1:0] ready_r;
  logic             busy_r, done_r, tx_r, tx_next_s;
  logic             tick_s, tick_next_s;
  logic [DIV_W-1:0] div_s;

  assign any_valid_s = |req_valid;
  assign div_s = baud_div(baud_r, DIV_W'(DIV_9600), DIV_W'(DIV_19200),
                          DIV_W'(DIV_38400), DIV_W'(DIV_57600));

  uart_baud_tick u_tick (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_r == ST_LOAD),
    .divisor   (div_s),
    .tick      (tick_s),
    .tick_next (tick_next_s)
  );

  // Rotating priority: scan downward so the nearest set bit after last_r wins.
  always_comb begin
    winner_s = last_r;
    for (int k = N_REQ; k >= 1; k--) begin
      winner_s = req_valid[(int'(last_r) + k) % N_REQ] ? GW'((int'(last_r) + k) % N_REQ) : winner_s;
    end
  end

  // Frame sequencing: every bit boundary is a divider tick.
  always_comb begin
    state_next_s = state_r;
    bit_next_s   = bit_r;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) state_next_s = ST_LOAD;
        else             state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        state_next_s = ST_START;
      end
      ST_START: begin
        if (tick_s) begin
          state_next_s = ST_DATA;
          bit_next_s   = 3'd0;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (bit_r == 3'd7) state_next_s = ST_STOP;
          else               bit_next_s   = bit_r + 3'd1;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) state_next_s = ST_IDLE;
        else        state_next_s = ST_STOP;
      end
      default: begin
        state_next_s = ST_IDLE;
        bit_next_s   = 3'd0;
      end
    endcase
  end

  // Line level for the coming cycle, so tx leaves a flop.
  always_comb begin
    case (state_next_s)
      ST_START: tx_next_s = 1'b0;
      ST_DATA:  tx_next_s = data_r[bit_next_s];
      default:  tx_next_s = 1'b1;
    endcase
  end

  // State, latched frame parameters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      bit_r   <= 3'd0;
      data_r  <= 8'd0;
      baud_r  <= 2'd0;
      last_r  <= GW'(N_REQ - 1);
      grant_r <= {GW{1'b0}};
      ready_r <= {N_REQ{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_next_s;
      bit_r   <= bit_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_STOP) && tick_next_s;
      tx_r    <= tx_next_s;
      if (state_r == ST_IDLE && any_valid_s) begin
        data_r  <= req_data[8*winner_s +: 8];
        baud_r  <= req_baud[2*winner_s +: 2];
        grant_r <= winner_s;
        last_r  <= winner_s;
        ready_r <= REQ_ONE << winner_s;
      end else begin
        ready_r <= {N_REQ{1'b0}};
      end
    end
  end

  assign req_ready  = ready_r;
  assign grant_id   = grant_r;
  assign busy       = busy_r;
  assign frame_done = done_r;
  assign tx         = tx_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-timeline reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int D0 = 16;
  localparam int D1 = 10;
  localparam int D2 = 6;
  localparam int D3 = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [2*N-1:0] req_baud;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic           frame_done;
  logic           tx;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  uart_tx_scheduler #(
    .N_REQ(N), .DIV_9600(D0), .DIV_19200(D1), .DIV_38400(D2), .DIV_57600(D3)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_baud(req_baud), .req_ready(req_ready), .grant_id(grant_id),
    .busy(busy), .frame_done(frame_done), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] c);
    return (c == 2'd0) ? D0 : (c == 2'd1) ? D1 : (c == 2'd2) ? D2 : D3;
  endfunction

  // Reference model: a frame granted in idle cycle t occupies t+1 (load) and
  // ten bit slots of div cycles from t+2; the next idle cycle is t+2+10*div.
  initial begin
    bit         m_active;
    longint     m_t;
    int         m_div, m_gid, m_last, m_grant, m_bit;
    logic [7:0] m_data;
    logic [N-1:0] e_ready;
    logic       e_busy, e_tx, e_fd;
    m_active = 1'b0; m_t = 0; m_div = 1; m_gid = 0; m_last = N - 1; m_grant = 0; m_data = 8'd0;
    forever begin
      @(negedge clk);
      e_ready = '0; e_busy = 1'b0; e_tx = 1'b1; e_fd = 1'b0;
      if (!rst) begin
        m_active = 1'b0; m_last = N - 1; m_grant = 0;
      end else if (m_active && cyc > m_t + 1 + 10 * m_div) begin
        m_active = 1'b0;
      end
      if (m_active) begin
        e_busy = 1'b1;
        if (cyc == m_t + 1) begin
          e_ready[m_gid] = 1'b1;
        end else begin
          m_bit = int'((cyc - m_t - 2) / m_div);
          e_tx  = (m_bit == 0) ? 1'b0 : (m_bit <= 8) ? m_data[m_bit-1] : 1'b1;
          e_fd  = (cyc == m_t + 1 + 10 * m_div);
        end
      end
      chk("req_ready", req_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("tx", tx, e_tx);
      chk("frame_done", frame_done, e_fd);
      chk("grant_id", grant_id, m_grant);
      if (rst && !m_active && req_valid != '0) begin
        m_gid = -1;
        for (int k = 1; k <= N; k++)
          if (m_gid < 0 && req_valid[(m_last + k) % N]) m_gid = (m_last + k) % N;
        m_active = 1'b1;
        m_t      = cyc;
        m_div    = div_of(req_baud[2*m_gid +: 2]);
        m_data   = req_data[8*m_gid +: 8];
        m_last   = m_gid;
        m_grant  = m_gid;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic [1:0] b);
    req_valid[i]       = v;
    req_data[8*i +: 8] = d;
    req_baud[2*i +: 2] = b;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 4000) begin step(); w++; end
    chk("idle_timeout", w >= 4000, 1'b0);
    step();
  endtask

  task automatic frame_len(input string tag, input int exp_len);
    int p, fd_p;
    p = 0;
    while (tx !== 1'b0 && p < 2000) begin step(); p++; end
    chk({tag, "_fall_timeout"}, p >= 2000, 1'b0);
    fd_p = -1;
    for (int q = 1; q <= 2000 && fd_p < 0; q++) begin
      step();
      if (frame_done) fd_p = q;
    end
    chk({tag, "_len"}, fd_p, exp_len);
  endtask

  initial begin
    int         fd_p, gap, w, r3;
    logic [9:0] pat;
    int         seq[$];
    int         rcnt[N];

    rst = 1'b0; req_valid = '0; req_data = '0; req_baud = '0;
    step(); step();
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_grant", grant_id, 2'd0);
    chk("reset_ready", req_ready, 4'b0000);
    rst = 1'b1;
    step();

    // Single request: byte 0x55 at the slowest rate.
    set_req(0, 1'b1, 8'h55, 2'b00);
    step();
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_busy", busy, 1'b1);
    req_valid[0] = 1'b0;
    step();
    chk("t1_tx_fall", tx, 1'b0);
    pat = '0; fd_p = -1;
    for (int q = 1; q <= 10 * D0 + 4; q++) begin
      step();
      if (q % D0 == D0 / 2) pat[q / D0] = tx;
      if (frame_done && fd_p < 0) fd_p = q;
    end
    chk("t1_bits", pat, 10'h2AA);
    chk("t1_len", fd_p, 10 * D0 - 1);
    wait_idle();

    // Contention after a fresh reset: strict rotation from requester 0.
    rst = 1'b0; step(); rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b1, 8'($urandom_range(255)), 2'b11);
      rcnt[i] = 0;
    end
    for (int c = 0; c < 5 * (10 * D3 + 3) && seq.size() < 5; c++) begin
      step();
      if (req_ready != '0) begin
        seq.push_back(int'(grant_id));
        for (int i = 0; i < N; i++) rcnt[i] += int'(req_ready[i]);
      end
    end
    chk("t2_frames", seq.size(), 5);
    for (int j = 0; j < seq.size(); j++) chk("t2_grant", seq[j], j % N);
    chk("t2_cnt0", rcnt[0], 2);
    for (int i = 1; i < N; i++) chk("t2_cnt", rcnt[i], 1);
    req_valid = '0;
    wait_idle();

    // Mixed rates: fast frame, two-clock gap after its stop bit, slow frame.
    set_req(1, 1'b1, 8'hA3, 2'b11);
    set_req(2, 1'b1, 8'h0F, 2'b00);
    step();
    chk("t3_ready1", req_ready, 4'b0010);
    req_valid[1] = 1'b0;
    frame_len("t3_f1", 10 * D3 - 1);
    gap = 0;
    while (tx !== 1'b0 && gap < 100) begin
      step(); gap++;
      if (req_ready[2]) req_valid[2] = 1'b0;
    end
    chk("t3_gap", gap, 3);
    frame_len("t3_f2", 10 * D0 - 1);
    wait_idle();

    // Inputs of the owning requester churn mid-frame; waveform must not move.
    set_req(0, 1'b1, 8'h3C, 2'b01);
    step();
    chk("t4_ready", req_ready, 4'b0001);
    req_valid[0] = 1'b0;
    step();
    fd_p = -1;
    for (int q = 1; q <= 10 * D1; q++) begin
      step();
      if (q >= 2 * D1 && q < 8 * D1) begin
        req_baud[1:0] = 2'($urandom_range(3));
        req_data[7:0] = 8'($urandom_range(255));
      end
      if (frame_done && fd_p < 0) fd_p = q;
    end
    chk("t4_len", fd_p, 10 * D1 - 1);
    wait_idle();

    // Reset inside data bit 4 (a zero bit), with requesters 2 and 3 pending.
    set_req(2, 1'b1, 8'hE5, 2'b10);
    step();
    chk("t5_ready", req_ready, 4'b0100);
    req_valid[2] = 1'b0;
    step();
    chk("t5_fall", tx, 1'b0);
    set_req(2, 1'b1, 8'h81, 2'b00);
    set_req(3, 1'b1, 8'h5A, 2'b11);
    repeat (5 * D2 + 2) step();
    chk("t5_pre_tx", tx, 1'b0);
    rst = 1'b0;
    #1;
    chk("t5_rst_tx", tx, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    step();
    rst = 1'b1;
    step();
    chk("t5_ready2", req_ready, 4'b0100);
    req_valid[2] = 1'b0;
    w = 0;
    while (!req_ready[3] && w < 400) begin step(); w++; end
    chk("t5_req3_served", req_ready[3], 1'b1);
    req_valid[3] = 1'b0;
    wait_idle();

    // Requester 3 is valid only while the line is busy: never granted.
    r3 = 0;
    set_req(0, 1'b1, 8'h96, 2'b11);
    step();
    req_valid[0] = 1'b0;
    for (int q = 0; q < 10 * D3 + 6; q++) begin
      step();
      if (q == 5) set_req(3, 1'b1, 8'h11, 2'b00);
      if (q == 20) req_valid[3] = 1'b0;
      if (req_ready[3]) r3++;
    end
    chk("t6_req3_never", r3, 0);
    wait_idle();

    // Random traffic, including requests withdrawn before being granted.
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (req_ready[i] || $urandom_range(63) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          set_req(i, 1'b1, 8'($urandom_range(255)), 2'($urandom_range(3)));
        end
      end
    end
    req_valid = '0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
